// File: rtl/apb_arbiter_pkg.sv
// rtl/apb_arbiter_pkg.sv - shared types and widths for the two-requester APB arbiter
package apb_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - two-way round-robin grant, one-hot out
module rr_arbiter
  import apb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[0] && req[1]) begin
      // contention: whoever was not served last wins
      grant = last_grant[0] ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - arbitrates two requesters onto one APB master with timeout
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          req_err,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [ADDR_W-1:0]           paddr,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [DATA_W-1:0]           pwdata,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  apb_state_e state, state_next;

  logic               gnt_idx;
  logic               rr_ptr;
  logic [7:0]         cnt;
  logic [7:0]         cnt_inc;
  logic               load;
  logic               done;
  logic               tmo;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] last_grant;
  logic [NUM_REQ-1:0] grant;

  // a requester being acked this cycle cannot be re-granted on the same edge
  assign eligible   = req_valid & ~req_ack;
  assign last_grant = rr_ptr ? 2'b01 : 2'b10;

  rr_arbiter u_rr (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // bus strobes come straight from the state so reset drops them at once
  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    cnt_inc    = sat_inc8(cnt);
    case (state)
      IDLE: begin
        if (|grant) begin
          load       = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (cnt_inc == TMO_LIMIT) begin
          done       = 1'b1;
          tmo        = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_idx   <= 1'b0;
      rr_ptr    <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      cnt       <= '0;
      req_ack   <= '0;
      req_err   <= '0;
      req_rdata <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      if (load) begin
        gnt_idx <= grant[1];
        rr_ptr  <= ~grant[1];
        pwrite  <= grant[1] ? req_write[1] : req_write[0];
        paddr   <= grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        pwdata  <= grant[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS && !pready) begin
        cnt <= cnt_inc;
      end
      if (done) begin
        req_ack[gnt_idx] <= 1'b1;
        req_err[gnt_idx] <= tmo;
        req_rdata        <= (pwrite || tmo) ? '0 : prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - directed and randomized checks of apb_arbiter against a transaction model
module tb_apb_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ack, req_err;
  logic [7:0]  req_rdata;
  logic [2:0]  paddr;
  logic        psel, penable, pwrite;
  logic [7:0]  pwdata, prdata;
  logic        pready;

  int checks = 0;
  int failures = 0;

  apb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  // transaction-level reference: busy flag, owner, phase (0 setup / 1 access), wait count
  bit         m_busy;
  int         m_who, m_phase, m_waits, m_prio;
  logic [1:0] m_ack, m_err;
  logic [7:0] m_rdata, m_pwdata;
  logic [2:0] m_paddr;
  logic       m_pwrite;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_who = 0; m_phase = 0; m_waits = 0; m_prio = 0;
    m_ack = 2'b00; m_err = 2'b00; m_rdata = 8'h00;
    m_paddr = 3'd0; m_pwrite = 1'b0; m_pwdata = 8'h00;
  endtask

  task automatic model_edge();
    logic [1:0] elig;
    int pick;
    elig  = req_valid & ~m_ack;
    m_ack = 2'b00;
    m_err = 2'b00;
    if (!m_busy) begin
      if (elig != 2'b00) begin
        pick = (elig == 2'b11) ? m_prio : (elig[1] ? 1 : 0);
        m_busy = 1'b1; m_who = pick; m_phase = 0; m_waits = 0; m_prio = 1 - pick;
        m_pwrite = req_write[pick];
        m_paddr  = req_addr[3*pick +: 3];
        m_pwdata = req_wdata[8*pick +: 8];
      end
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (pready) begin
      m_ack[m_who] = 1'b1;
      m_rdata = m_pwrite ? 8'h00 : prdata;
      m_busy = 1'b0;
    end else begin
      m_waits++;
      if (m_waits == TO) begin
        m_ack[m_who] = 1'b1;
        m_err[m_who] = 1'b1;
        m_rdata = 8'h00;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("psel", 16'(psel), 16'(m_busy));
    chk("penable", 16'(penable), 16'(m_busy && m_phase == 1));
    chk("paddr", 16'(paddr), 16'(m_paddr));
    chk("pwrite", 16'(pwrite), 16'(m_pwrite));
    chk("pwdata", 16'(pwdata), 16'(m_pwdata));
    chk("req_ack", 16'(req_ack), 16'(m_ack));
    chk("req_err", 16'(req_err), 16'(m_err));
    chk("req_rdata", 16'(req_rdata), 16'(m_rdata));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int lat;
    logic [1:0] exp_ack;

    rst = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = 6'd0; req_wdata = 16'd0;
    prdata = 8'h00; pready = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // requester 0 read, zero wait states
    req_valid = 2'b01; req_write = 2'b00; req_addr = 6'd0; prdata = 8'hA5; pready = 1'b1;
    cycle(); chk("rd_psel_e0", 16'(psel), 16'd1); chk("rd_pen_e0", 16'(penable), 16'd0);
    cycle(); chk("rd_pen_e1", 16'(penable), 16'd1);
    cycle(); chk("rd_ack", 16'(req_ack), 16'h1); chk("rd_rdata", 16'(req_rdata), 16'hA5);
    chk("rd_err", 16'(req_err), 16'h0);
    req_valid = 2'b00;
    cycle();

    // requester 1 write
    req_valid = 2'b10; req_write = 2'b10; req_addr = 6'd0; req_wdata = 16'h3C00; prdata = 8'h5A;
    cycle(); chk("wr_pwrite_setup", 16'(pwrite), 16'd1); chk("wr_pwdata_setup", 16'(pwdata), 16'h3C);
    cycle(); chk("wr_pwrite_acc", 16'(pwrite), 16'd1); chk("wr_pwdata_acc", 16'(pwdata), 16'h3C);
    cycle(); chk("wr_ack", 16'(req_ack), 16'h2); chk("wr_rdata", 16'(req_rdata), 16'h00);
    req_valid = 2'b00; req_write = 2'b00;
    cycle();

    // three wait states
    req_valid = 2'b01; req_addr = 6'd5; prdata = 8'h77; pready = 1'b0; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      cycle();
      if (req_ack != 2'b00) begin lat = n; break; end
      if (n == 5) pready = 1'b1;
    end
    chk("wait3_latency", 16'(lat), 16'd6);
    chk("wait3_err", 16'(req_err), 16'h0);
    chk("wait3_rdata", 16'(req_rdata), 16'h77);
    req_valid = 2'b00;
    cycle();

    // pready held low: timeout on requester 1
    req_valid = 2'b10; req_addr = 6'o40; prdata = 8'hEE; pready = 1'b0; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      cycle();
      if (req_ack != 2'b00) begin lat = n; break; end
    end
    chk("tmo_latency", 16'(lat), 16'd18);
    chk("tmo_ack", 16'(req_ack), 16'h2);
    chk("tmo_err", 16'(req_err), 16'h2);
    chk("tmo_rdata", 16'(req_rdata), 16'h00);
    req_valid = 2'b00;
    cycle();

    // pready arrives in the last ACCESS cycle before timeout: no error
    req_valid = 2'b01; req_addr = 6'd3; prdata = 8'h5C; pready = 1'b0; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      cycle();
      if (req_ack != 2'b00) begin lat = n; break; end
      if (n == 17) pready = 1'b1;
    end
    chk("edge_latency", 16'(lat), 16'd18);
    chk("edge_err", 16'(req_err), 16'h0);
    chk("edge_rdata", 16'(req_rdata), 16'h5C);
    req_valid = 2'b00;
    cycle();

    // continuous contention: requester 0 served last, so 1 goes first, then alternate
    req_valid = 2'b11; req_write = 2'b00; req_addr = {3'd3, 3'd1}; pready = 1'b1; prdata = 8'h99;
    exp_ack = 2'b10;
    for (int n = 0; n < 18; n++) begin
      cycle();
      chk("rr_not_both", 16'(req_ack == 2'b11), 16'd0);
      if (req_ack != 2'b00) begin
        chk("rr_alternate", 16'(req_ack), 16'(exp_ack));
        exp_ack = exp_ack ^ 2'b11;
      end
    end
    req_valid = 2'b00;
    repeat (4) cycle();

    // reset during ACCESS
    req_valid = 2'b10; req_addr = 6'o70; pready = 1'b0;
    cycle(); cycle();
    chk("rst_pre_pen", 16'(penable), 16'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_psel", 16'(psel), 16'd0);
    chk("rst_pen", 16'(penable), 16'd0);
    chk("rst_ack", 16'(req_ack), 16'd0);
    model_reset();
    cycle(); cycle();
    rst = 1'b1; req_valid = 2'b11; req_addr = {3'd6, 3'd2}; pready = 1'b1;
    cycle();
    chk("rst_first_grant", 16'(paddr), 16'd2);
    cycle(); cycle();
    chk("rst_first_ack", 16'(req_ack), 16'h1);
    req_valid = 2'b00;
    repeat (4) cycle();

    // randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 1200; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && m_ack[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[3*i +: 3] = 3'($urandom_range(0, 7));
          req_wdata[8*i +: 8] = 8'($urandom_range(0, 255));
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_write[i] = 1'($urandom_range(0, 1));
            req_addr[3*i +: 3] = 3'($urandom_range(0, 7));
            req_wdata[8*i +: 8] = 8'($urandom_range(0, 255));
          end
        end else if (m_busy && m_who == i && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      pready = (n < 600) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      prdata = 8'($urandom_range(0, 255));
      cycle();
    end
    req_valid = 2'b00;
    repeat (25) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
